operand_sweep_gen: RTL and testbench

OPERAND_SWEEP_GEN -- requirements
Module: operand_sweep_gen

---
 rtl/operand_sweep_gen.sv | 246 ++++++++++++++++++++++++
 tb/tb_operand_sweep_gen.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_sweep_gen.sv
// -----------------------------------------------------------------------------
// operand_sweep_gen
//
// Purpose:
//   Exhaustive operand sweep generator. NCH operand channels of SB swept bits
//   each are stepped through every combination as a nested counter. Channel
//   NCH-1 is the fastest and channel 0 the slowest. One combination is
//   presented per beat on a valid/ready stream. A sweep is exactly
//   2^(NCH*SB) accepted beats. A response from the unit under test can
//   optionally be folded into a 32-bit rotate-XOR signature.
//
// Parameters:
//   W    width of each operand channel on out_data (1..31)
//   SB   swept bits per channel (1..W)
//   NCH  number of operand channels (1..8)
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse, begins a sweep (ignored while running)
//   abort      terminates the sweep, returns to IDLE (wins over start)
//   out_valid  beat on out_data is valid (only while running)
//   out_ready  sink accepts the beat
//   out_data   channel k in bits [k*W +: W], zero-extended from SB bits
//   out_last   current beat is the final beat of the sweep
//   beat_idx   flattened index {ch0, ch1, ..., ch(NCH-1)}, ch0 in the MSBs
//   busy       FSM in RUN
//   done       FSM in DONE
//   rsp        response of the unit under test, sampled on accepted beats
//   sig        response signature
//
// Configuration:
//   SWEEP_SIGNATURE_EN  when defined, sig is a rotate-XOR signature of rsp.
//                       It is cleared by an honoured start and updated on
//                       every accepted beat. When undefined, sig is tied to
//                       zero, rsp is ignored, and no signature flops exist.
// -----------------------------------------------------------------------------
module operand_sweep_gen #(
    parameter int W   = 19,
    parameter int SB  = 4,
    parameter int NCH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NCH*W-1:0]  out_data,
    output logic              out_last,
    output logic [NCH*SB-1:0] beat_idx,
    output logic              busy,
    output logic              done,
    input  logic [W:0]        rsp,
    output logic [31:0]       sig
);

    localparam int IW = NCH * SB;
    localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
    localparam logic [IW-1:0] IDX_LAST = {IW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [IW-1:0]   idx_r;
    logic            valid_r;
    logic            last_r;
    logic            busy_r;
    logic            done_r;

    logic            accept_s;
    logic            launch_s;
    logic [IW-1:0]   idx_next_s;
    logic [NCH*W-1:0] out_data_s;

    // The channel counters are concatenated with ch0 in the MSBs and the
    // fastest channel in the LSBs. A plain binary increment of this
    // flattened index is therefore exactly the nested sweep: each SB-bit
    // field wraps from all-ones to zero and carries into the next slower
    // channel.
    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] idx);
        return idx + IW'(1'b1);
    endfunction

    // Handshake and sweep-launch qualifiers. Abort outranks start, and
    // start is only honoured outside RUN.
    always_comb begin
        accept_s   = valid_r & out_ready;
        launch_s   = start & ~abort & (state_r != ST_RUN);
        idx_next_s = idx_inc(idx_r);
    end

    // Sweep FSM with registered stream and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= IDX_ZERO;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (launch_s) begin
                        state_r <= ST_RUN;
                        idx_r   <= IDX_ZERO;
                        valid_r <= 1'b1;
                        last_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                        idx_r   <= IDX_ZERO;
                        valid_r <= 1'b0;
                        last_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        // A beat handshaken in this same cycle still counts
                        // (the signature sees it). The sweep does not
                        // complete, though.
                        state_r <= ST_IDLE;
                        idx_r   <= IDX_ZERO;
                        valid_r <= 1'b0;
                        last_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end else if (accept_s) begin
                        if (last_r) begin
                            // idx_r stays at all-ones while parked in DONE.
                            state_r <= ST_DONE;
                            idx_r   <= idx_r;
                            valid_r <= 1'b0;
                            last_r  <= 1'b0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                            idx_r   <= idx_next_s;
                            valid_r <= 1'b1;
                            last_r  <= (idx_next_s == IDX_LAST);
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end
                    end else begin
                        // Stalled: the presented beat holds still.
                        state_r <= ST_RUN;
                        idx_r   <= idx_r;
                        valid_r <= 1'b1;
                        last_r  <= last_r;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                        idx_r   <= IDX_ZERO;
                        valid_r <= 1'b0;
                        last_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end else if (launch_s) begin
                        state_r <= ST_RUN;
                        idx_r   <= IDX_ZERO;
                        valid_r <= 1'b1;
                        last_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= ST_DONE;
                        idx_r   <= idx_r;
                        valid_r <= 1'b0;
                        last_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    idx_r   <= IDX_ZERO;
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Spread the flattened index back out into zero-extended channel fields.
    // Channel k lives in index bits [(NCH-1-k)*SB +: SB].
    always_comb begin
        out_data_s = {(NCH*W){1'b0}};
        for (int k = 0; k < NCH; k++) begin
            out_data_s[k*W +: SB] = idx_r[(NCH-1-k)*SB +: SB];
        end
    end

    assign out_valid = valid_r;
    assign out_last  = last_r;
    assign out_data  = out_data_s;
    assign beat_idx  = idx_r;
    assign busy      = busy_r;
    assign done      = done_r;

`ifdef SWEEP_SIGNATURE_EN
    logic [31:0] sig_r;

    // One signature step: rotate left by one, then fold in the response.
    function automatic logic [31:0] sig_step(input logic [31:0] cur,
                                             input logic [W:0]  resp);
        return {cur[30:0], cur[31]} ^ 32'(resp);
    endfunction

    // Signature register. It clears on an honoured start and folds rsp in
    // on every accepted beat, including one accepted alongside abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_r <= 32'h0000_0000;
        end else if (launch_s) begin
            sig_r <= 32'h0000_0000;
        end else if (accept_s) begin
            sig_r <= sig_step(sig_r, rsp);
        end else begin
            sig_r <= sig_r;
        end
    end

    assign sig = sig_r;
`else
    // Signature disabled: rsp is deliberately ignored.
    logic rsp_unused_s;
    assign rsp_unused_s = ^rsp;
    assign sig          = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_operand_sweep_gen.sv
module tb_operand_sweep_gen;

    localparam int W   = 19;
    localparam int SB  = 4;
    localparam int NCH = 3;
    localparam int IW  = NCH * SB;
    localparam int DW  = NCH * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [IW-1:0] beat_idx;
    logic          busy;
    logic          done;
    logic [W:0]    rsp;
    logic [31:0]   sig;

    // second, small instance: NCH=1, SB=2
    logic          s_start;
    logic          s_abort;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  s_data;
    logic          s_last;
    logic [1:0]    s_idx;
    logic          s_busy;
    logic          s_done;
    logic [W:0]    s_rsp;
    logic [31:0]   s_sig;

    int errors = 0;
    int checks = 0;
    int accepted = 0;
    logic [IW-1:0] exp_q[$];
    logic [31:0]   model_sig = 32'h0;

    always #5 clk = ~clk;

    function automatic logic [W:0] rsp_f(input logic [IW-1:0] i);
        return ({8'h00, i} * 20'd13) + 20'd5;
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [IW-1:0] i);
        logic [DW-1:0] d;
        d = {DW{1'b0}};
        d[3:0]   = i[11:8];   // ch0
        d[22:19] = i[7:4];    // ch1
        d[41:38] = i[3:0];    // ch2
        return d;
    endfunction

    assign rsp = rsp_f(beat_idx);

    operand_sweep_gen #(.W(W), .SB(SB), .NCH(NCH)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .beat_idx(beat_idx), .busy(busy), .done(done),
        .rsp(rsp), .sig(sig)
    );

    operand_sweep_gen #(.W(W), .SB(2), .NCH(1)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
        .out_valid(s_valid), .out_ready(s_ready), .out_data(s_data),
        .out_last(s_last), .beat_idx(s_idx), .busy(s_busy), .done(s_done),
        .rsp(s_rsp), .sig(s_sig)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard: pops one expectation per accepted beat and checks
    // that a stalled beat holds still.
    initial begin
        logic          stall_prev;
        logic [DW-1:0] held_data;
        logic [IW-1:0] held_idx;
        logic          held_last;
        logic [IW-1:0] e;
        stall_prev = 1'b0;
        held_data  = '0;
        held_idx   = '0;
        held_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (stall_prev && out_valid && rst_n) begin
                chk("stall hold data", 64'(out_data), 64'(held_data));
                chk("stall hold idx",  64'(beat_idx), 64'(held_idx));
                chk("stall hold last", 64'(out_last), 64'(held_last));
            end
            stall_prev = out_valid && !out_ready && rst_n;
            held_data  = out_data;
            held_idx   = beat_idx;
            held_last  = out_last;
            if (out_valid && out_ready) begin
                accepted++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected beat: got idx 0x%0h expected none", beat_idx);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_idx", 64'(beat_idx), 64'(e));
                    chk("out_data", 64'(out_data), 64'(exp_data(e)));
                    chk("out_last", 64'(out_last), 64'(e == 12'hFFF));
                    if (e == 12'd17)
                        chk("beat 17 data", 64'(out_data), 64'h0000_0040_0008_0000);
                    if (e == 12'hFFF)
                        chk("last beat data", 64'(out_data), 64'h0000_03C0_0078_000F);
                    model_sig = {model_sig[30:0], model_sig[31]} ^ {12'h000, rsp_f(e)};
                end
            end
        end
    end

    function automatic logic [31:0] exp_sig();
`ifdef SWEEP_SIGNATURE_EN
        return model_sig;
`else
        return 32'h0;
`endif
    endfunction

    task automatic push_range(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(IW'(i));
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        model_sig = 32'h0;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Run up to beat n, abort while beat n is presented (with out_ready=1).
    task automatic run_abort(input int n, input string tag);
        push_range(n + 1);
        pulse_start();
        repeat (n) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk({tag, " valid after abort"}, 64'(out_valid), 64'd0);
        chk({tag, " idx after abort"},   64'(beat_idx),  64'd0);
        chk({tag, " busy after abort"},  64'(busy),      64'd0);
        chk({tag, " done after abort"},  64'(done),      64'd0);
        chk({tag, " queue drained"},     64'(exp_q.size()), 64'd0);
        chk({tag, " sig after abort"},   64'(sig),       64'(exp_sig()));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        s_start = 1'b0; s_abort = 1'b0; s_ready = 1'b1; s_rsp = 20'd1;
        #2 rst_n = 1'b0;
        #20;
        chk("reset valid", 64'(out_valid), 64'd0);
        chk("reset busy",  64'(busy),      64'd0);
        chk("reset done",  64'(done),      64'd0);
        chk("reset idx",   64'(beat_idx),  64'd0);
        chk("reset data",  64'(out_data),  64'd0);
        chk("reset sig",   64'(sig),       64'd0);
        @(negedge clk) rst_n = 1'b1;

        // Full sweep, ready held high; start during RUN must be ignored.
        push_range(4096);
        accepted = 0;
        pulse_start();
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            chk("gapless valid", 64'(out_valid), 64'd1);
            if (i == 0) chk("first data zero", 64'(out_data), 64'd0);
            @(posedge clk);
            #1 start = (i == 49);
        end
        start = 1'b0;
        @(negedge clk);
        chk("done after sweep",  64'(done),      64'd1);
        chk("valid in done",     64'(out_valid), 64'd0);
        chk("busy in done",      64'(busy),      64'd0);
        chk("idx holds in done", 64'(beat_idx),  64'hFFF);
        chk("sweep1 beats",      64'(accepted),  64'd4096);
        chk("sweep1 queue",      64'(exp_q.size()), 64'd0);
        chk("sweep1 sig",        64'(sig),       64'(exp_sig()));

        // Restart from DONE, then sweep with out_ready toggling.
        push_range(4096);
        accepted = 0;
        pulse_start();
        @(negedge clk);
        chk("restart sig clear", 64'(sig),       64'd0);
        chk("restart idx",       64'(beat_idx),  64'd0);
        chk("restart valid",     64'(out_valid), 64'd1);
        cyc = 0;
        while (!done && cyc < 20000) begin
            @(posedge clk);
            #1 out_ready = ~out_ready;
            cyc++;
        end
        out_ready = 1'b1;
        chk("toggle sweep finished", 64'(done), 64'd1);
        @(negedge clk);
        chk("toggle beats", 64'(accepted),     64'd4096);
        chk("toggle queue", 64'(exp_q.size()), 64'd0);
        chk("toggle sig",   64'(sig),          64'(exp_sig()));

        // Abort beats start in DONE.
        @(posedge clk);
        #1 begin start = 1'b1; abort = 1'b1; end
        @(posedge clk);
        #1 begin start = 1'b0; abort = 1'b0; end
        @(negedge clk);
        chk("abort>start valid", 64'(out_valid), 64'd0);
        chk("abort>start done",  64'(done),      64'd0);
        chk("abort>start busy",  64'(busy),      64'd0);

        // Abort with handshake at beat 0x123.
        run_abort(12'h123, "abort123");

        // Asynchronous reset mid-sweep at beat 100.
        push_range(100);
        pulse_start();
        repeat (100) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst valid", 64'(out_valid), 64'd0);
        chk("async rst last",  64'(out_last),  64'd0);
        chk("async rst busy",  64'(busy),      64'd0);
        chk("async rst done",  64'(done),      64'd0);
        chk("async rst idx",   64'(beat_idx),  64'd0);
        chk("async rst data",  64'(out_data),  64'd0);
        chk("async rst sig",   64'(sig),       64'd0);
        chk("async rst queue", 64'(exp_q.size()), 64'd0);
        model_sig = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("no beat in reset", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("no beat before start", 64'(out_valid), 64'd0);
        run_abort(4, "post-reset");

        // Small instance: 4 beats, rsp=1 -> sig 0xF with the signature enabled.
        @(posedge clk);
        #1 s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("small valid", 64'(s_valid), 64'd1);
            chk("small idx",   64'(s_idx),   64'(i));
            chk("small data",  64'(s_data),  64'(i));
            chk("small last",  64'(s_last),  64'(i == 3));
            @(posedge clk);
        end
        @(negedge clk);
        chk("small done", 64'(s_done), 64'd1);
`ifdef SWEEP_SIGNATURE_EN
        chk("small sig", 64'(s_sig), 64'h0000_000F);
`else
        chk("small sig", 64'(s_sig), 64'h0000_0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
